// File: rtl/accum_core.sv
// ---------------------------------------------------------------------------
// accum_core
//   Multicycle accumulator processor. Fetches 8-bit instructions through a
//   request/valid handshake, executes them on a DATA_W accumulator plus a
//   4-entry register file, and supports relative branch-on-zero and halt.
//
// Ports
//   clk          : rising-edge clock for all state
//   rst          : asynchronous active-low reset
//   instruction  : instruction word, sampled when fetch_req & instr_valid
//   instr_valid  : memory qualifier for instruction
//   fetch_req    : registered, high while waiting for an instruction
//   address      : registered PC, used as the fetch address
//   result       : registered accumulator
//   zero         : combinational (accumulator == 0)
//   halted       : registered, high once HLT has executed
// ---------------------------------------------------------------------------
module accum_core #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        instruction,
   input  logic              instr_valid,
   output logic              fetch_req,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              halted
);

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_LDI = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_MOV = 3'b100,
      OP_MVA = 3'b101,
      OP_BZ  = 3'b110,
      OP_HLT = 3'b111
   } opcode_t;

   localparam logic [ADDR_W-1:0] PC_RESET_VAL = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] PC_ONE       = ADDR_W'(1'b1);
   localparam logic [DATA_W-1:0] DATA_ZERO    = {DATA_W{1'b0}};

   // Sign-extend the 5-bit immediate to the datapath width.
   function automatic logic [DATA_W-1:0] sext_data(input logic [4:0] v);
      return DATA_W'($signed(v));
   endfunction

   // Sign-extend (or truncate, for narrow PCs) the 5-bit branch offset;
   // the add that uses it is modulo 2^ADDR_W either way.
   function automatic logic [ADDR_W-1:0] sext_addr(input logic [4:0] v);
      return ADDR_W'($signed(v));
   endfunction

   state_t            state_q,     state_d;
   logic [ADDR_W-1:0] pc_q,        pc_d;
   logic [7:0]        ir_q,        ir_d;
   logic [DATA_W-1:0] acc_q,       acc_d;
   logic [DATA_W-1:0] rf_q [4];
   logic [DATA_W-1:0] rf_d [4];
   logic              fetch_req_q, fetch_req_d;
   logic              halted_q,    halted_d;

   opcode_t           op_s;
   logic [4:0]        imm5_s;
   logic [1:0]        reg_sel_s;
   logic [DATA_W-1:0] rs_val_s;
   logic              acc_zero_s;

   assign op_s       = opcode_t'(ir_q[7:5]);
   assign imm5_s     = ir_q[4:0];
   assign reg_sel_s  = ir_q[1:0];
   assign rs_val_s   = rf_q[reg_sel_s];
   assign acc_zero_s = (acc_q == DATA_ZERO);

   // Next-state, handshake and datapath update logic.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      acc_d       = acc_q;
      rf_d        = rf_q;
      fetch_req_d = fetch_req_q;
      halted_d    = halted_q;

      case (state_q)
         ST_START: begin
            state_d     = ST_FETCH;
            fetch_req_d = 1'b1;
         end

         ST_FETCH: begin
            // fetch_req is always high here, so instr_valid alone qualifies.
            if (instr_valid) begin
               ir_d        = instruction;
               fetch_req_d = 1'b0;
               state_d     = ST_EXEC;
            end else begin
               state_d = ST_FETCH;
            end
         end

         ST_EXEC: begin
            state_d     = ST_FETCH;
            fetch_req_d = 1'b1;
            pc_d        = pc_q + PC_ONE;
            case (op_s)
               OP_NOP: begin
                  acc_d = acc_q;
               end
               OP_LDI: begin
                  acc_d = sext_data(imm5_s);
               end
               OP_ADD: begin
                  acc_d = acc_q + rs_val_s;
               end
               OP_SUB: begin
                  acc_d = acc_q - rs_val_s;
               end
               OP_MOV: begin
                  rf_d[reg_sel_s] = acc_q;
               end
               OP_MVA: begin
                  acc_d = rs_val_s;
               end
               OP_BZ: begin
                  // Offset is relative to the BZ's own address.
                  if (acc_zero_s) begin
                     pc_d = pc_q + sext_addr(imm5_s);
                  end else begin
                     pc_d = pc_q + PC_ONE;
                  end
               end
               OP_HLT: begin
                  pc_d        = pc_q;
                  state_d     = ST_HALT;
                  fetch_req_d = 1'b0;
                  halted_d    = 1'b1;
               end
               default: begin
                  acc_d = acc_q;
               end
            endcase
         end

         ST_HALT: begin
            state_d     = ST_HALT;
            fetch_req_d = 1'b0;
            halted_d    = 1'b1;
         end

         default: begin
            state_d     = ST_START;
            fetch_req_d = 1'b0;
         end
      endcase
   end

   // State registers; reset drops fetch_req immediately toward the memory.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_START;
         pc_q        <= PC_RESET_VAL;
         ir_q        <= 8'h00;
         acc_q       <= DATA_ZERO;
         rf_q[0]     <= DATA_ZERO;
         rf_q[1]     <= DATA_ZERO;
         rf_q[2]     <= DATA_ZERO;
         rf_q[3]     <= DATA_ZERO;
         fetch_req_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         acc_q       <= acc_d;
         rf_q        <= rf_d;
         fetch_req_q <= fetch_req_d;
         halted_q    <= halted_d;
      end
   end

   assign fetch_req = fetch_req_q;
   assign address   = pc_q;
   assign result    = acc_q;
   assign zero      = acc_zero_s;
   assign halted    = halted_q;

endmodule
